// File: rtl/zero_sink.sv
`default_nettype none
// ============================================================================
// Module      : zero_sink
// Description : Dataflow self-check sink. Accepts a run of N samples, checks
//               each against zero, counts samples and mismatches, captures the
//               index/value of the first non-zero sample and reports pass/fail.
// Revision    : 1.0 - initial release
// ============================================================================
module zero_sink #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              zero_sink_clk,
    input  logic              zero_sink_reset,
    input  logic              zero_sink_init,
    input  logic              zero_sink_in_disable,
    input  logic              zero_sink_start,
    input  logic [CNT_W-1:0]  zero_sink_in_len,
    input  logic              zero_sink_in_valid,
    input  logic [DATA_W-1:0] zero_sink_in_data,
    output logic              zero_sink_out_busy,
    output logic              zero_sink_out_done,
    output logic              zero_sink_out_pass,
    output logic [CNT_W-1:0]  zero_sink_out_sample_cnt,
    output logic [CNT_W-1:0]  zero_sink_out_err_cnt,
    output logic [CNT_W-1:0]  zero_sink_out_first_err_idx,
    output logic [DATA_W-1:0] zero_sink_out_first_err_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_zero = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic [CNT_W-1:0]    r_len;
    logic [CNT_W-1:0]    r_sample_cnt;
    logic [CNT_W-1:0]    r_err_cnt;
    logic [CNT_W-1:0]    r_first_err_idx;
    logic [DATA_W-1:0]   r_first_err_data;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;

    logic                w_start_ok;
    logic                w_accept;
    logic                w_nonzero;
    logic                w_first_err;
    logic                w_last;
    logic [CNT_W-1:0]    w_sample_cnt_nxt;
    logic [CNT_W-1:0]    w_err_cnt_nxt;

    // Decode of the accept/mismatch conditions for the current cycle
    always_comb begin
        w_start_ok       = (r_state == ST_IDLE) && zero_sink_start && !zero_sink_in_disable;
        w_accept         = (r_state == ST_RUN) && zero_sink_in_valid && !zero_sink_in_disable;
        w_nonzero        = |zero_sink_in_data;
        // "first" mismatch: nothing counted yet in this run
        w_first_err      = w_accept && w_nonzero && (r_err_cnt == c_cnt_zero);
        w_sample_cnt_nxt = r_sample_cnt + c_cnt_one;
        w_last           = w_accept && (w_sample_cnt_nxt == r_len);
        w_err_cnt_nxt    = r_err_cnt;
        if (w_accept && w_nonzero && (r_err_cnt != c_cnt_max)) begin
            w_err_cnt_nxt = r_err_cnt + c_cnt_one;
        end
    end

    // Run-control FSM with all result registers; init behaves like reset
    always_ff @(posedge zero_sink_clk or negedge zero_sink_reset) begin
        if (!zero_sink_reset) begin
            r_state          <= ST_IDLE;
            r_len            <= c_cnt_zero;
            r_sample_cnt     <= c_cnt_zero;
            r_err_cnt        <= c_cnt_zero;
            r_first_err_idx  <= c_cnt_zero;
            r_first_err_data <= {DATA_W{1'b0}};
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
        end else if (zero_sink_init) begin
            r_state          <= ST_IDLE;
            r_len            <= c_cnt_zero;
            r_sample_cnt     <= c_cnt_zero;
            r_err_cnt        <= c_cnt_zero;
            r_first_err_idx  <= c_cnt_zero;
            r_first_err_data <= {DATA_W{1'b0}};
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_start_ok) begin
                        r_len            <= zero_sink_in_len;
                        r_sample_cnt     <= c_cnt_zero;
                        r_err_cnt        <= c_cnt_zero;
                        r_first_err_idx  <= c_cnt_zero;
                        r_first_err_data <= {DATA_W{1'b0}};
                        if (zero_sink_in_len == c_cnt_zero) begin
                            // Empty run: straight to DONE, trivially passing
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                            r_pass  <= 1'b0;
                        end
                    end
                end

                ST_RUN: begin
                    if (w_accept) begin
                        r_sample_cnt <= w_sample_cnt_nxt;
                        r_err_cnt    <= w_err_cnt_nxt;
                        if (w_first_err) begin
                            r_first_err_idx  <= r_sample_cnt;
                            r_first_err_data <= zero_sink_in_data;
                        end
                        if (w_last) begin
                            // Verdict uses the count including this sample
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_cnt_nxt == c_cnt_zero);
                        end
                    end
                end

                ST_DONE: begin
                    // Single-cycle state; disable and start have no effect here
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign zero_sink_out_busy           = r_busy;
    assign zero_sink_out_done           = r_done;
    assign zero_sink_out_pass           = r_pass;
    assign zero_sink_out_sample_cnt     = r_sample_cnt;
    assign zero_sink_out_err_cnt        = r_err_cnt;
    assign zero_sink_out_first_err_idx  = r_first_err_idx;
    assign zero_sink_out_first_err_data = r_first_err_data;

endmodule
`default_nettype wire

// File: doc/zero_sink.md
Name: zero_sink

Overview:
- Stream-consuming counterpart of the constant-zero source generator.
- Accepts a run of N samples from a dataflow output, checks each against zero, and counts samples and mismatches.
- Captures the index and value of the first non-zero sample, then reports pass/fail.
- Sits at the end of a dataflow chain as a self-check sink for zero-initialised and zero-driven paths.

Parameters:
DATA_W, 32, width of checked sample
CNT_W, 16, width of length, index and counters

Ports:
zero_sink_clk  in  1  clock; all logic on rising edge
zero_sink_reset  in  1  reset, asynchronous, active-low
zero_sink_init  in  1  synchronous clear; same effect as reset
zero_sink_in_disable  in  1  stall; when 1, no sample is accepted and the state is held
zero_sink_start  in  1  begin run (IDLE only)
zero_sink_in_len  in  CNT_W  samples expected in run; sampled on accepted start
zero_sink_in_valid  in  1  sample present
zero_sink_in_data  in  DATA_W  sample
zero_sink_out_busy  out  1  1 in RUN
zero_sink_out_done  out  1  one-cycle pulse at end of run
zero_sink_out_pass  out  1  1 if last completed run had zero mismatches
zero_sink_out_sample_cnt  out  CNT_W  samples accepted in current/last run
zero_sink_out_err_cnt  out  CNT_W  non-zero samples, saturating at 2^CNT_W-1
zero_sink_out_first_err_idx  out  CNT_W  0-based index of first non-zero sample
zero_sink_out_first_err_data  out  DATA_W  value of first non-zero sample

Behaviour:
- Reset (async, reset low) or init=1 at an edge:
  - state=IDLE.
  - All outputs 0: busy=0, done=0, pass=0, counters 0, first_err_* 0.
  - init has priority over all other inputs.
- FSM states: IDLE, RUN, DONE, registered, one state per cycle.
- IDLE:
  - start=1 with disable=0: latch len; clear sample_cnt, err_cnt and first_err_*; clear pass.
  - If len=0, next state is DONE; otherwise next state is RUN.
  - valid in IDLE is ignored.
- RUN:
  - busy=1.
  - Sample accepted on an edge with valid=1 and disable=0.
  - On accept, sample_cnt increments.
  - If data!=0: err_cnt increments, saturating.
  - If data!=0 and it is the first mismatch of the run: first_err_idx = sample_cnt value before the increment, first_err_data = data.
  - When the accepted sample makes sample_cnt equal to the latched len, next state is DONE.
  - start in RUN is ignored.
- DONE:
  - Lasts exactly one cycle with disable ignored.
  - done=1; pass = (err_cnt==0); busy=0.
  - Next state is IDLE.
  - start in DONE is ignored.
- Results (pass, counters, first_err_*) hold until the next accepted start, init or reset.
- Latency: done rises one cycle after the edge that accepts the last sample. For len=0, done rises one cycle after the accepted start.
- disable=1 in RUN: the sample is not counted even if valid=1, and all registers hold.
- Saturation: err_cnt stops at 2^CNT_W-1; sample_cnt cannot exceed len.
- A zero sample never touches first_err_*.
- Reset or init mid-run: the run is aborted with no done pulse, and all outputs are 0.
- In is_first_err, "first" means err_cnt==0 before the sample is accepted.
- pass reads 0 while a run is in progress.

Test Plan:
1. len=4, four samples 0,0,0,0 with valid=1 back-to-back -> busy=1 for 4 cycles, then done pulse; pass=1, sample_cnt=4, err_cnt=0, first_err_idx=0.
2. len=5, samples 0,0,0xDEAD,0,0x1 -> pass=0, err_cnt=2, first_err_idx=2, first_err_data=0xDEAD.
3. len=3, valid toggling with disable=1 held for 2 cycles mid-run (valid=1 during disable) -> samples under disable are not counted; done arrives only after 3 accepted samples; sample_cnt=3.
4. len=0 start -> done on the next cycle, busy never 1, pass=1, sample_cnt=0; a second start while in DONE is ignored.
5. len=6, reset asserted low after 3 samples (2 non-zero) -> immediate IDLE, all outputs 0 with no done pulse; repeat with init=1 instead -> same result at the next edge.
6. CNT_W=4, len=15, all samples 0xFF -> err_cnt=15 (saturated), first_err_idx=0, pass=0; start during RUN is ignored (len is not relatched).
